// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and step-counter sizing.
package seq_shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The step counter must be able to hold values up to width.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEFAULT_CNT_W = count_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_shift_add_multiplier_adder.sv
// Ripple-carry N-bit full adder used as the multiplier's single
// partial-product accumulator.
module NbitFullAdder #(
  parameter int width = 8
) (
  input  logic [width-1:0] i_a,
  input  logic [width-1:0] i_b,
  input  logic             i_cin,
  output logic [width-1:0] o_sum,
  output logic             o_cout
);

  logic [width:0] w_carry;

  assign w_carry[0] = i_cin;

  // One full-adder cell per bit; carry ripples from LSB to MSB.
  for (genvar gi = 0; gi < width; gi++) begin : g_bit
    assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) |
                             (i_a[gi] & w_carry[gi]) |
                             (i_b[gi] & w_carry[gi]);
  end

  assign o_cout = w_carry[width];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 sequential unsigned multiplier. One partial product is added
// per clock; {C,A,Q} is shifted right each step so that after width
// steps {A,Q} holds the 2*width-bit product.
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int width = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*width-1:0] product
);

  localparam int CNT_W = count_width(width);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(width - 1);

  state_t               r_state;
  logic [width-1:0]     r_m;
  logic [width-1:0]     r_q;
  logic [width-1:0]     r_a;
  logic [CNT_W-1:0]     r_count;
  logic [2*width-1:0]   r_product;

  logic [width-1:0]     w_addend;
  logic [width-1:0]     w_sum;
  logic                 w_cout;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign w_addend = r_q[0] ? r_m : '0;

  NbitFullAdder #(.width(width)) u_adder (
    .i_a    (r_a),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // FSM, accumulator/shift register, step counter and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_m       <= '0;
      r_q       <= '0;
      r_a       <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_m     <= a;
            r_q     <= b;
            r_a     <= '0;
            r_count <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Right shift of {C,S,Q}: the carry-out lands in A's MSB,
          // the sum LSB moves into Q's MSB, Q[0] is consumed.
          r_a     <= {w_cout, w_sum[width-1:1]};
          r_q     <= {w_sum[0], r_q[width-1:1]};
          r_count <= r_count + 1'b1;
          if (r_count == LAST_STEP) begin
            r_product <= {w_cout, w_sum, r_q[width-1:1]};
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier: the driver pushes the
// expected product of each accepted request, the monitor pops and
// compares on every done pulse, also checking latency and period.
module tb_seq_shift_add_multiplier;

  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] prod;
    int             acc;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
  } exp_t;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  int   last_done;
  bit   b2b;
  bit   chk_after;

  seq_shift_add_multiplier #(.width(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Global safety net.
  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Monitor: compare each done pulse against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk_after = 1'b0;
      end else begin
        if (chk_after) begin
          chk_after = 1'b0;
          checks++;
          if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_done busy=%b done=%b required busy=0 done=0", busy, done);
          end
        end
        if (done === 1'b1) begin
          chk_after = 1'b1;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done product=%h with no pending request", product);
          end else begin
            e = sb.pop_front();
            if (product !== e.prod) begin
              errors++;
              $display("FAIL product %0d*%0d got %h required %h", e.x, e.y, product, e.prod);
            end else begin
              $display("op %0d*%0d -> %0d", e.x, e.y, product);
            end
            checks++;
            if (cyc - e.acc != W) begin
              errors++;
              $display("FAIL latency got %0d required %0d", cyc - e.acc, W);
            end
            if (b2b && last_done >= 0) begin
              checks++;
              if (cyc - last_done != W + 2) begin
                errors++;
                $display("FAIL period got %0d required %0d", cyc - last_done, W + 2);
              end
            end
            last_done = cyc;
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    e.acc  = cyc + 1;
    e.x    = x;
    e.y    = y;
    sb.push_back(e);
  endtask

  // One-cycle start pulse; expectation queued only if the DUT is idle.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    if (!busy) push_exp(x, y);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_%s pending=%0d busy=%b required pending=0 busy=0", name, sb.size(), busy);
    end
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL %s busy=%b done=%b product=%h required 0 0 0000", name, busy, done, product);
    end
  endtask

  initial begin
    int n;
    int guard;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    last_done = -1;
    b2b       = 1'b0;
    chk_after = 1'b0;
    reset     = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;

    repeat (2) @(negedge clk);
    check_cleared("reset_state");
    reset = 1'b0;

    issue(8'd13, 8'd11);  drain("13x11");
    issue(8'hFF, 8'hFF);  drain("FFxFF");
    issue(8'h00, 8'hA5);  drain("00xA5");
    issue(8'h5A, 8'h00);  drain("5Ax00");

    // Restart attempt while busy must be ignored.
    issue(8'd7, 8'd9);
    repeat (3) @(negedge clk);
    issue(8'd3, 8'd3);
    drain("7x9_ignore");

    // Asynchronous reset mid-operation, after four steps.
    issue(8'd9, 8'd5);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_cleared("reset_mid_run");
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    issue(8'd2, 8'd3);    drain("2x3");

    // Start held high: back-to-back random operations.
    b2b       = 1'b1;
    last_done = -1;
    a         = 8'($urandom);
    b         = 8'($urandom);
    n         = 0;
    guard     = 0;
    while (n < 1000 && guard < 20000) begin
      @(negedge clk);
      start = 1'b1;
      if (!busy) begin
        push_exp(a, b);
        n++;
      end else begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      guard++;
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (n != 1000) begin
      errors++;
      $display("FAIL b2b_accepts got %0d required 1000", n);
    end
    drain("b2b");
    b2b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
